// File: rtl/bbc_micro_ram_types.sv
// bbc_micro_ram_types: shared types for the BBC micro main-RAM arbiter.
// Provides the access owner enum, the SRAM request record and the
// response tag that travels down the read-latency delay line.
package bbc_micro_ram_types;

    typedef enum logic [1:0] {
        RAM_OWNER_NONE,
        RAM_OWNER_VIDEO,
        RAM_OWNER_CPU,
        RAM_OWNER_HOST
    } t_ram_owner;

    typedef struct packed {
        logic        valid;
        logic        read_not_write;
        logic [15:0] address;
        logic [7:0]  write_data;
    } t_ram_request;

    typedef struct packed {
        t_ram_owner owner;
        logic       read_not_write;
    } t_ram_tag;

    localparam t_ram_request REQ_NONE = '0;
    localparam t_ram_tag     TAG_NONE = '{owner: RAM_OWNER_NONE, read_not_write: 1'b0};

endpackage

// File: rtl/bbc_micro_ram_response_pipe.sv
// bbc_micro_ram_response_pipe: LATENCY-deep delay line for access owner tags.
// Ports: clk, clk__enable (advance only when high), reset_n (async, active low),
//        tag_in (tag of the access granted this cycle),
//        tag_out (tag whose SRAM read data is on the bus this cycle).
module bbc_micro_ram_response_pipe
    import bbc_micro_ram_types::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     clk__enable,
    input  logic     reset_n,
    input  t_ram_tag tag_in,
    output t_ram_tag tag_out
);

    t_ram_tag stages [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) stages[i] <= TAG_NONE;
        end else if (clk__enable) begin
            stages[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) stages[i] <= stages[i-1];
        end
    end

    assign tag_out = stages[LATENCY-1];

endmodule

// File: rtl/bbc_micro_ram_arbiter.sv
// bbc_micro_ram_arbiter: shares the 8-bit main SRAM between video, CPU and host.
// Ports: clk/clk__enable/reset_n; video_enable and cpu_enable slot strobes;
//        video_req__*, cpu_req__*, host_req__* requests; sram_req__* registered
//        SRAM access and sram_read_data return; per-requester read data and
//        valid/ack pulses; host_busy (host access in flight); cpu_overrun (sticky).
module bbc_micro_ram_arbiter
    import bbc_micro_ram_types::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        video_enable,
    input  logic        cpu_enable,
    input  logic        video_req__valid,
    input  logic [14:0] video_req__address,
    input  logic        cpu_req__valid,
    input  logic        cpu_req__read_not_write,
    input  logic [15:0] cpu_req__address,
    input  logic [7:0]  cpu_req__write_data,
    input  logic        host_req__valid,
    input  logic        host_req__read_not_write,
    input  logic [15:0] host_req__address,
    input  logic [7:0]  host_req__write_data,
    input  logic [7:0]  sram_read_data,
    output logic        sram_req__valid,
    output logic        sram_req__read_not_write,
    output logic [15:0] sram_req__address,
    output logic [7:0]  sram_req__write_data,
    output logic [7:0]  video_read_data,
    output logic        video_read_data_valid,
    output logic [7:0]  cpu_read_data,
    output logic        cpu_read_data_valid,
    output logic [7:0]  host_read_data,
    output logic        host_ack,
    output logic        host_busy,
    output logic        cpu_overrun
);

    logic         cpu_pending;
    t_ram_request cpu_held;
    t_ram_request video_in, cpu_in, host_in, grant;
    t_ram_owner   grant_owner;
    t_ram_tag     resp;
    logic         video_go, cpu_new, host_go;

    assign video_go = video_enable & video_req__valid;
    assign cpu_new  = cpu_enable & cpu_req__valid;
    assign host_go  = host_req__valid & !host_busy;

    assign video_in = '{1'b1, 1'b1, {1'b0, video_req__address}, 8'h00};
    assign cpu_in   = '{1'b1, cpu_req__read_not_write, cpu_req__address, cpu_req__write_data};
    assign host_in  = '{1'b1, host_req__read_not_write, host_req__address, host_req__write_data};

    // A deferred CPU access goes ahead of everything so the CPU loses at most one slot.
    assign grant = cpu_pending ? cpu_held : video_go ? video_in : cpu_new ? cpu_in :
                   host_go ? host_in : REQ_NONE;
    assign grant_owner = cpu_pending ? RAM_OWNER_CPU : video_go ? RAM_OWNER_VIDEO :
                         cpu_new ? RAM_OWNER_CPU : host_go ? RAM_OWNER_HOST : RAM_OWNER_NONE;

    bbc_micro_ram_response_pipe #(.LATENCY(READ_LATENCY)) response_pipe (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset_n     (reset_n),
        .tag_in      ('{owner: grant_owner, read_not_write: grant.read_not_write}),
        .tag_out     (resp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_req__valid          <= 1'b0;
            sram_req__read_not_write <= 1'b0;
            sram_req__address        <= '0;
            sram_req__write_data     <= '0;
            video_read_data          <= '0;
            video_read_data_valid    <= 1'b0;
            cpu_read_data            <= '0;
            cpu_read_data_valid      <= 1'b0;
            host_read_data           <= '0;
            host_ack                 <= 1'b0;
            host_busy                <= 1'b0;
            cpu_overrun              <= 1'b0;
            cpu_pending              <= 1'b0;
            cpu_held                 <= REQ_NONE;
        end else if (clk__enable) begin
            sram_req__valid <= grant.valid;
            if (grant.valid) begin
                sram_req__read_not_write <= grant.read_not_write;
                sram_req__address        <= grant.address;
                sram_req__write_data     <= grant.write_data;
            end
            // Capture only when video steals the CPU slot; a second CPU request
            // arriving while one is held is dropped and flagged.
            cpu_pending <= !cpu_pending & video_go & cpu_new;
            if (!cpu_pending) cpu_held <= cpu_in;
            cpu_overrun <= cpu_overrun | (cpu_pending & cpu_new);
            host_busy <= (host_busy & (resp.owner != RAM_OWNER_HOST)) | (grant_owner == RAM_OWNER_HOST);
            video_read_data_valid <= (resp.owner == RAM_OWNER_VIDEO) & resp.read_not_write;
            cpu_read_data_valid   <= (resp.owner == RAM_OWNER_CPU) & resp.read_not_write;
            host_ack              <= resp.owner == RAM_OWNER_HOST;
            if ((resp.owner == RAM_OWNER_VIDEO) & resp.read_not_write) video_read_data <= sram_read_data;
            if ((resp.owner == RAM_OWNER_CPU) & resp.read_not_write) cpu_read_data <= sram_read_data;
            if ((resp.owner == RAM_OWNER_HOST) & resp.read_not_write) host_read_data <= sram_read_data;
        end
    end

endmodule
